// File: rtl/cpu_bus_ctrl.sv
// CPU bus decoder for the WCD6502 core: work RAM, PPU register window and a PRG/mapper
// window reached over a req/ack handshake, with an open-bus read latch.
module cpu_bus_ctrl #(
    parameter int RAM_AW      = 11,
    parameter int EXT_AW      = 15,
    parameter int EXT_TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              nRst,
    input  logic [15:0]       AB,
    input  logic [7:0]        DB,
    input  logic              nRD,
    input  logic              nWR,
    output logic [7:0]        DB_IN,
    output logic              rd_valid,
    output logic              Rdy,
    output logic              ppu_cs,
    output logic              ppu_we,
    output logic [2:0]        ppu_addr,
    output logic [7:0]        ppu_wdata,
    input  logic [7:0]        ppu_rdata,
    output logic              ext_req,
    output logic              ext_we,
    output logic [EXT_AW-1:0] ext_addr,
    output logic [7:0]        ext_wdata,
    input  logic              ext_ack,
    input  logic [7:0]        ext_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        PPU,
        EXT_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_PPU,
        REG_UNMAPPED,
        REG_EXT
    } region_t;

    localparam int          RAM_DEPTH = 1 << RAM_AW;
    localparam logic [7:0]  TO_LAST   = 8'(EXT_TIMEOUT - 1);

    function automatic region_t decode(input logic [15:0] addr);
        if (addr[15])
            return REG_EXT;
        else if (addr[14])
            return REG_UNMAPPED;
        else if (addr[13])
            return REG_PPU;
        else
            return REG_RAM;
    endfunction

    state_t      state;
    region_t     region;
    logic        strobe;
    logic        is_wr;
    logic [7:0]  open_bus;
    logic [7:0]  ram_q;
    logic        ram_rd;
    logic [7:0]  to_cnt;
    logic [7:0]  ram [0:RAM_DEPTH-1];

    // A write strobe wins when both strobes are low together.
    assign strobe = !nRD || !nWR;
    assign is_wr  = !nWR;
    assign region = decode(AB);

    // Work RAM: write and registered read share the decoded index; no reset on storage.
    always_ff @(posedge Clk) begin
        if (state == IDLE && strobe && is_wr && region == REG_RAM)
            ram[AB[RAM_AW-1:0]] <= DB;
        ram_q <= ram[AB[RAM_AW-1:0]];
    end

    // RAM read data comes straight off the BRAM port for one cycle, then lives in the latch.
    assign DB_IN = ram_rd ? ram_q : open_bus;

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            open_bus  <= 8'h00;
            ram_rd    <= 1'b0;
            rd_valid  <= 1'b0;
            Rdy       <= 1'b1;
            ppu_cs    <= 1'b0;
            ppu_we    <= 1'b0;
            ppu_addr  <= 3'd0;
            ppu_wdata <= 8'h00;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= 8'h00;
            to_cnt    <= 8'd0;
            bus_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            ram_rd   <= 1'b0;
            ppu_cs   <= 1'b0;
            if (ram_rd)
                open_bus <= ram_q;

            case (state)
                IDLE: begin
                    if (strobe) begin
                        if (is_wr)
                            open_bus <= DB;
                        case (region)
                            REG_RAM: begin
                                if (!is_wr) begin
                                    ram_rd   <= 1'b1;
                                    rd_valid <= 1'b1;
                                end
                            end
                            REG_PPU: begin
                                ppu_cs    <= 1'b1;
                                ppu_we    <= is_wr;
                                ppu_addr  <= AB[2:0];
                                ppu_wdata <= DB;
                                Rdy       <= 1'b0;
                                state     <= PPU;
                            end
                            REG_UNMAPPED: begin
                                if (!is_wr)
                                    rd_valid <= 1'b1;
                            end
                            default: begin
                                ext_req   <= 1'b1;
                                ext_we    <= is_wr;
                                ext_addr  <= AB[EXT_AW-1:0];
                                ext_wdata <= DB;
                                to_cnt    <= 8'd0;
                                Rdy       <= 1'b0;
                                state     <= EXT_WAIT;
                            end
                        endcase
                    end
                end

                PPU: begin
                    if (strobe)
                        bus_err <= 1'b1;
                    if (!ppu_we) begin
                        open_bus <= ppu_rdata;
                        rd_valid <= 1'b1;
                    end
                    Rdy   <= 1'b1;
                    state <= IDLE;
                end

                EXT_WAIT: begin
                    if (strobe)
                        bus_err <= 1'b1;
                    if (ext_ack) begin
                        ext_req <= 1'b0;
                        if (!ext_we) begin
                            open_bus <= ext_rdata;
                            rd_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (to_cnt == TO_LAST) begin
                        // Abort: the read still completes, but with the open-bus value.
                        ext_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!ext_we)
                            rd_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end

                DONE: begin
                    if (strobe)
                        bus_err <= 1'b1;
                    Rdy   <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    Rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
